// File: rtl/led_pkg.sv
// Shared definitions for the bicolour LED pattern generator: mode codes,
// write-FSM encoding and the per-LED mode/phase decode.
package led_pkg;

  localparam int NUM_LEDS = 12;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_OFF     = 3'd0;
  localparam mode_t MODE_A       = 3'd1;
  localparam mode_t MODE_B       = 3'd2;
  localparam mode_t MODE_BLEND   = 3'd3;
  localparam mode_t MODE_BLINK_A = 3'd4;
  localparam mode_t MODE_BLINK_B = 3'd5;
  localparam mode_t MODE_ALT     = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [3:0] IDX_ALL = 4'd15;

  // Returns {yr, bg}; code 7 is reserved and falls through to OFF.
  function automatic logic [1:0] decode_mode(input mode_t mode, input logic phase);
    logic [1:0] res;
    case (mode)
      MODE_A:       res = 2'b10;
      MODE_B:       res = 2'b01;
      MODE_BLEND:   res = 2'b11;
      MODE_BLINK_A: res = {phase, 1'b0};
      MODE_BLINK_B: res = {1'b0, phase};
      MODE_ALT:     res = {~phase, phase};
      default:      res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Host write port of the pattern generator: valid/ready mode writes plus the
// invalid-index error pulse.
interface led_pattern_gen_if;

  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_idx;
  led_pkg::mode_t    wr_mode;
  logic              wr_err;

  modport master (output wr_valid, wr_idx, wr_mode, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_idx, wr_mode, output wr_ready, wr_err);

endinterface

// File: rtl/led_prescaler.sv
// Free-running blink prescaler; phase flips on the cycle the counter wraps
// from all-ones back to zero.
module led_prescaler #(
  parameter int BLINK_DIV = 22
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  logic [BLINK_DIV-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= cnt + BLINK_DIV'(1);
      if (&cnt) phase <= ~phase;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Bicolour LED pattern generator: holds a 3-bit mode per LED, written singly
// or all-at-once, and emits registered colour A/B request vectors.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int BLINK_DIV = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pattern_gen_if.slave    wr,
  output logic [NUM_LEDS-1:0] led_yr,
  output logic [NUM_LEDS-1:0] led_bg
);

  logic [0:0]    state;
  logic [3:0]    fill_ctr;
  mode_t         fill_mode;
  mode_t         modes [NUM_LEDS];
  logic          err_q;
  logic          phase;
  logic          accept;
  logic [NUM_LEDS-1:0] yr_d;
  logic [NUM_LEDS-1:0] bg_d;

  led_prescaler #(.BLINK_DIV(BLINK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase)
  );

  assign wr.wr_ready = (state == ST_IDLE);
  assign wr.wr_err   = err_q;
  assign accept      = wr.wr_valid && wr.wr_ready;

  // NOTE: the mode file is reset explicitly so a reset mid-fill discards
  // partial contents and every LED comes back OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fill_ctr  <= '0;
      fill_mode <= MODE_OFF;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) modes[i] <= MODE_OFF;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (wr.wr_idx < 4'(NUM_LEDS)) begin
              for (int i = 0; i < NUM_LEDS; i++)
                if (wr.wr_idx == 4'(i)) modes[i] <= wr.wr_mode;
            end else if (wr.wr_idx == IDX_ALL) begin
              fill_mode <= wr.wr_mode;
              fill_ctr  <= '0;
              state     <= ST_FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          for (int i = 0; i < NUM_LEDS; i++)
            if (fill_ctr == 4'(i)) modes[i] <= fill_mode;
          if (fill_ctr == 4'(NUM_LEDS - 1)) state <= ST_IDLE;
          else fill_ctr <= fill_ctr + 4'd1;
        end
      endcase
    end
  end

  // NOTE: defaults first so no path through always_comb can infer a latch.
  always_comb begin
    yr_d = '0;
    bg_d = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      {yr_d[i], bg_d[i]} = decode_mode(modes[i], phase);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_yr <= '0;
      led_bg <= '0;
    end else begin
      led_yr <= yr_d;
      led_bg <= bg_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen with a 16-cycle blink period.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] led_yr;
  logic [11:0] led_bg;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  led_pattern_gen_if wr_bus ();

  led_pattern_gen #(.BLINK_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (wr_bus),
    .led_yr (led_yr),
    .led_bg (led_bg)
  );

  always #5 clk = ~clk;

  // Edges seen since the last reset release; the prescaler equals cyc mod 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a write, wait for ready, and return at the negedge after acceptance.
  task automatic send(input logic [3:0] idx, input logic [2:0] mode);
    int waits = 0;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_idx   = idx;
    wr_bus.wr_mode  = mode;
    while (!wr_bus.wr_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    check("send_ready", 32'(wr_bus.wr_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lowcnt;
    logic ph;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_idx   = 4'd0;
    wr_bus.wr_mode  = 3'd0;

    // Reset, then idle.
    repeat (2) @(negedge clk);
    check("rst_yr", 32'(led_yr), 32'h000);
    check("rst_ready", 32'(wr_bus.wr_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_yr", 32'(led_yr), 32'h000);
      check("idle_bg", 32'(led_bg), 32'h000);
      check("idle_ready", 32'(wr_bus.wr_ready), 32'd1);
      check("idle_err", 32'(wr_bus.wr_err), 32'd0);
    end

    // Back-to-back single writes; the output lags the entry by one cycle.
    send(4'd3, 3'd1);
    send(4'd7, 3'd2);
    send(4'd9, 3'd3);
    wr_bus.wr_valid = 1'b0;
    check("lat1_yr", 32'(led_yr), 32'h008);
    check("lat1_bg", 32'(led_bg), 32'h080);
    @(negedge clk);
    check("single_yr", 32'(led_yr), 32'h208);
    check("single_bg", 32'(led_bg), 32'h280);

    // Blink A on LED0 and ALT on LED1 follow the prescaler phase.
    send(4'd0, 3'd4);
    send(4'd1, 3'd6);
    wr_bus.wr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ph = 1'(((cyc - 1) >> 4) & 1);
      check("blink_yr", 32'(led_yr), 32'(12'h208 | {10'b0, ~ph, ph}));
      check("blink_bg", 32'(led_bg), 32'(12'h280 | {10'b0, ph, 1'b0}));
    end

    // Fill all with A while a follow-up write to idx 2 is held pending.
    send(4'd15, 3'd1);
    wr_bus.wr_idx  = 4'd2;
    wr_bus.wr_mode = 3'd0;
    lowcnt = 0;
    while (!wr_bus.wr_ready && lowcnt < 64) begin
      lowcnt++;
      @(negedge clk);
    end
    check("fill_ready_low", 32'(lowcnt), 32'd12);
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
    check("fill_yr", 32'(led_yr), 32'hFFF);
    check("fill_bg", 32'(led_bg), 32'h000);
    @(negedge clk);
    check("after_fill_yr", 32'(led_yr), 32'hFFB);
    check("after_fill_bg", 32'(led_bg), 32'h000);

    // Invalid indices: one error pulse each, outputs untouched.
    send(4'd13, 3'd1);
    wr_bus.wr_valid = 1'b0;
    check("err_hi", 32'(wr_bus.wr_err), 32'd1);
    @(negedge clk);
    check("err_lo", 32'(wr_bus.wr_err), 32'd0);
    check("err_yr", 32'(led_yr), 32'hFFB);
    send(4'd12, 3'd1);
    check("err2_first", 32'(wr_bus.wr_err), 32'd1);
    send(4'd14, 3'd3);
    wr_bus.wr_valid = 1'b0;
    check("err2_second", 32'(wr_bus.wr_err), 32'd1);
    @(negedge clk);
    check("err2_lo", 32'(wr_bus.wr_err), 32'd0);
    check("err2_yr", 32'(led_yr), 32'hFFB);
    check("err2_bg", 32'(led_bg), 32'h000);

    // Reset part-way through a fill with B.
    send(4'd15, 3'd2);
    wr_bus.wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midfill_yr", 32'(led_yr), 32'hFF8);
    check("midfill_bg", 32'(led_bg), 32'h007);
    rst_n = 1'b0;
    #1;
    check("rstfill_yr", 32'(led_yr), 32'h000);
    check("rstfill_bg", 32'(led_bg), 32'h000);
    check("rstfill_err", 32'(wr_bus.wr_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("post_rst_yr", 32'(led_yr), 32'h000);
      check("post_rst_bg", 32'(led_bg), 32'h000);
      check("post_rst_ready", 32'(wr_bus.wr_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
